gmii_receive_parse: RTL

//  GMII receive-side framer for a network_rx port; the receive counterpart of the GMII transmit path.

---
 rtl/gmii_receive_parse_pkg.sv | 20 ++
 rtl/gmii_receive_parse.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/gmii_receive_parse_pkg.sv
// Purpose: shared constants and state encoding for the GMII receive framer.
//   PREAMBLE_BYTE / SFD_BYTE : frame delimiter bytes seen on the GMII rx bus
//   state_t                  : framer states (IDLE_S, PREAMBLE_S, DATA_S, DROP_S)
package gmii_receive_parse_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned LEN_W     = 11;
  localparam int unsigned PRE_CNT_W = 3;

  localparam logic [BYTE_W-1:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [BYTE_W-1:0] SFD_BYTE      = 8'hD5;

  typedef enum logic [1:0] {
    IDLE_S     = 2'd0,
    PREAMBLE_S = 2'd1,
    DATA_S     = 2'd2,
    DROP_S     = 2'd3
  } state_t;

endpackage

// File: rtl/gmii_receive_parse.sv
// Purpose: GMII receive-side framer. Strips preamble/SFD, forwards frame bytes
//   (DA..FCS) with head/tail marks, and flags rx_er, preamble, runt and
//   oversize conditions on the frame tail and as single-cycle pulses.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   iv_gmii_rxd[7:0]        GMII receive data
//   i_gmii_rx_dv            GMII receive data valid
//   i_gmii_rx_er            GMII receive error
//   ov_pkt_data[7:0]        frame byte, qualified by o_pkt_data_wr
//   o_pkt_data_wr           frame byte strobe
//   o_pkt_head, o_pkt_tail  first/last byte marks
//   o_pkt_err               frame bad, valid with o_pkt_tail
//   ov_pkt_len[10:0]        frame byte count, valid with o_pkt_tail
//   o_rx_err_pulse          first rx_er of a frame
//   o_preamble_err_pulse    preamble/SFD violation, frame dropped
//   o_len_err_pulse         runt or oversize frame
module gmii_receive_parse
  import gmii_receive_parse_pkg::*;
#(
  parameter int unsigned MIN_PKT_LEN  = 64,
  parameter int unsigned MAX_PKT_LEN  = 1522,
  parameter int unsigned MAX_PREAMBLE = 7
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  iv_gmii_rxd,
  input  logic        i_gmii_rx_dv,
  input  logic        i_gmii_rx_er,
  output logic [7:0]  ov_pkt_data,
  output logic        o_pkt_data_wr,
  output logic        o_pkt_head,
  output logic        o_pkt_tail,
  output logic        o_pkt_err,
  output logic [10:0] ov_pkt_len,
  output logic        o_rx_err_pulse,
  output logic        o_preamble_err_pulse,
  output logic        o_len_err_pulse
);

  state_t               r_state;
  logic [PRE_CNT_W-1:0] r_pre_cnt;
  logic [LEN_W-1:0]     r_len;
  logic [BYTE_W-1:0]    r_stash;
  logic                 r_err;

  // Stash holds frame byte 1 exactly when one byte has been received.
  logic w_stash_is_first;
  logic w_runt;
  assign w_stash_is_first = (r_len == LEN_W'(1));
  assign w_runt           = (r_len < LEN_W'(MIN_PKT_LEN));

  // Framer FSM with registered outputs; strobes and pulses default low each cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state              <= IDLE_S;
      r_pre_cnt            <= '0;
      r_len                <= '0;
      r_stash              <= '0;
      r_err                <= 1'b0;
      ov_pkt_data          <= '0;
      o_pkt_data_wr        <= 1'b0;
      o_pkt_head           <= 1'b0;
      o_pkt_tail           <= 1'b0;
      o_pkt_err            <= 1'b0;
      ov_pkt_len           <= '0;
      o_rx_err_pulse       <= 1'b0;
      o_preamble_err_pulse <= 1'b0;
      o_len_err_pulse      <= 1'b0;
    end else begin
      ov_pkt_data          <= '0;
      o_pkt_data_wr        <= 1'b0;
      o_pkt_head           <= 1'b0;
      o_pkt_tail           <= 1'b0;
      o_pkt_err            <= 1'b0;
      ov_pkt_len           <= '0;
      o_rx_err_pulse       <= 1'b0;
      o_preamble_err_pulse <= 1'b0;
      o_len_err_pulse      <= 1'b0;

      case (r_state)
        IDLE_S: begin
          if (i_gmii_rx_dv) begin
            if (iv_gmii_rxd == PREAMBLE_BYTE) begin
              r_state   <= PREAMBLE_S;
              r_pre_cnt <= PRE_CNT_W'(1);
            end else begin
              r_state              <= DROP_S;
              o_preamble_err_pulse <= 1'b1;
            end
          end
        end

        PREAMBLE_S: begin
          if (!i_gmii_rx_dv) begin
            r_state              <= IDLE_S;
            o_preamble_err_pulse <= 1'b1;
          end else if (i_gmii_rx_er) begin
            r_state              <= DROP_S;
            o_preamble_err_pulse <= 1'b1;
          end else if (iv_gmii_rxd == PREAMBLE_BYTE) begin
            // One more 0x55 beyond the limit is a violation; counter never exceeds the limit.
            if (r_pre_cnt >= PRE_CNT_W'(MAX_PREAMBLE)) begin
              r_state              <= DROP_S;
              o_preamble_err_pulse <= 1'b1;
            end else begin
              r_pre_cnt <= r_pre_cnt + PRE_CNT_W'(1);
            end
          end else if (iv_gmii_rxd == SFD_BYTE) begin
            r_state <= DATA_S;
            r_len   <= '0;
            r_err   <= 1'b0;
          end else begin
            r_state              <= DROP_S;
            o_preamble_err_pulse <= 1'b1;
          end
        end

        DATA_S: begin
          if (!i_gmii_rx_dv) begin
            // End of frame: flush the stash as tail (nothing to flush for an empty frame).
            r_state <= IDLE_S;
            if (r_len != '0) begin
              ov_pkt_data   <= r_stash;
              o_pkt_data_wr <= 1'b1;
              o_pkt_head    <= w_stash_is_first;
              o_pkt_tail    <= 1'b1;
              o_pkt_err     <= r_err | w_runt;
              ov_pkt_len    <= r_len;
            end
            if (w_runt) begin
              o_len_err_pulse <= 1'b1;
            end
          end else if (r_len == LEN_W'(MAX_PKT_LEN)) begin
            // Oversize: close the frame on the stashed byte and discard the rest.
            r_state         <= DROP_S;
            ov_pkt_data     <= r_stash;
            o_pkt_data_wr   <= 1'b1;
            o_pkt_head      <= w_stash_is_first;
            o_pkt_tail      <= 1'b1;
            o_pkt_err       <= 1'b1;
            ov_pkt_len      <= LEN_W'(MAX_PKT_LEN);
            o_len_err_pulse <= 1'b1;
          end else begin
            r_len   <= r_len + LEN_W'(1);
            r_stash <= iv_gmii_rxd;
            if (r_len != '0) begin
              ov_pkt_data   <= r_stash;
              o_pkt_data_wr <= 1'b1;
              o_pkt_head    <= w_stash_is_first;
            end
            if (i_gmii_rx_er) begin
              r_err <= 1'b1;
              if (!r_err) begin
                o_rx_err_pulse <= 1'b1;
              end
            end
          end
        end

        DROP_S: begin
          if (!i_gmii_rx_dv) begin
            r_state <= IDLE_S;
          end
        end

        default: r_state <= IDLE_S;
      endcase
    end
  end

endmodule
